// File: rtl/timer_pkg.sv
// Shared types and constants for the timer counter block.
// Optional input capture is enabled by defining TIMER_CAPTURE_EN.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    DONE    = 2'd2
  } timer_state_e;

  localparam int FLAG_OVF = 0;
  localparam int FLAG_CMP = 1;
  localparam int FLAG_CAP = 2;

`ifdef TIMER_CAPTURE_EN
  localparam int NUM_FLAGS = 3;
`else
  localparam int NUM_FLAGS = 2;
`endif

endpackage

// File: rtl/timer_counter_if.sv
// Control/status bundle between software-facing logic and the timer counter.
// Capture signals exist only when TIMER_CAPTURE_EN is defined.
interface timer_counter_if #(parameter int WIDTH = 16);
  import timer_pkg::*;

  logic                 clock_valid;
  logic                 start;
  logic                 stop;
  logic                 one_shot;
  logic [WIDTH-1:0]     period;
  logic [WIDTH-1:0]     compare;
  logic                 load;
  logic [WIDTH-1:0]     load_value;
  logic [NUM_FLAGS-1:0] flag_clr;
  logic [NUM_FLAGS-1:0] irq_en;
  logic [WIDTH-1:0]     count;
  logic                 running;
  logic                 ovf_flag;
  logic                 cmp_flag;
  logic                 irq;
`ifdef TIMER_CAPTURE_EN
  logic                 capture_in;
  logic [WIDTH-1:0]     capture_value;
  logic                 cap_flag;
`endif

  modport master (
    output clock_valid, start, stop, one_shot, period, compare,
           load, load_value, flag_clr, irq_en,
`ifdef TIMER_CAPTURE_EN
    output capture_in,
    input  capture_value, cap_flag,
`endif
    input  count, running, ovf_flag, cmp_flag, irq
  );

  modport slave (
    input  clock_valid, start, stop, one_shot, period, compare,
           load, load_value, flag_clr, irq_en,
`ifdef TIMER_CAPTURE_EN
    input  capture_in,
    output capture_value, cap_flag,
`endif
    output count, running, ovf_flag, cmp_flag, irq
  );

endinterface

// File: rtl/timer_edge_detect.sv
// Two-flop synchronizer for an asynchronous input plus a one-cycle rising-edge pulse.
module timer_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  // [0],[1] synchronize; [2] is the previous synchronized value
  logic [2:0] sync_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[1:0], async_in};
  end

  assign rise = sync_pipe[1] & ~sync_pipe[2];

endmodule

// File: rtl/timer_counter.sv
// Programmable up-counter with periodic/one-shot modes, compare match and sticky flags.
// Define TIMER_CAPTURE_EN to add the asynchronous input-capture register and cap_flag.
module timer_counter
  import timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  timer_counter_if.slave bus
);

  timer_state_e         state, state_nxt;
  logic [WIDTH-1:0]     count_q, count_nxt, count_inc;
  logic                 running_q;
  logic [NUM_FLAGS-1:0] flags_q, flag_set;
  logic                 tick, at_period;

`ifdef TIMER_CAPTURE_EN
  logic             cap_rise;
  logic [WIDTH-1:0] capture_q;

  timer_edge_detect u_cap_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (bus.capture_in),
    .rise     (cap_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        capture_q <= '0;
    else if (cap_rise) capture_q <= count_q;
  end

  assign bus.capture_value = capture_q;
  assign bus.cap_flag      = flags_q[FLAG_CAP];
`endif

  always_comb begin
    // load pre-empts a tick, so a loading cycle never raises flags
    tick      = (state == RUNNING) && bus.clock_valid && !bus.load;
    at_period = (count_q == bus.period);
    // count above period runs on to all-ones and wraps silently
    count_inc = at_period ? '0 : count_q + WIDTH'(1);
    count_nxt = count_q;
    flag_set  = '0;
    if (bus.load) begin
      count_nxt = bus.load_value;
    end else if (tick) begin
      count_nxt          = count_inc;
      flag_set[FLAG_OVF] = at_period;
      flag_set[FLAG_CMP] = (count_inc == bus.compare);
    end
`ifdef TIMER_CAPTURE_EN
    flag_set[FLAG_CAP] = cap_rise;
`endif

    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.start && !bus.stop) state_nxt = RUNNING;
      RUNNING: begin
        if (bus.stop)                                   state_nxt = IDLE;
        else if (flag_set[FLAG_OVF] && bus.one_shot)    state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      running_q <= 1'b0;
      count_q   <= '0;
      flags_q   <= '0;
    end else begin
      state     <= state_nxt;
      running_q <= (state_nxt == RUNNING);
      count_q   <= count_nxt;
      // a new event beats a simultaneous clear
      flags_q   <= flag_set | (flags_q & ~bus.flag_clr);
    end
  end

  assign bus.count    = count_q;
  assign bus.running  = running_q;
  assign bus.ovf_flag = flags_q[FLAG_OVF];
  assign bus.cmp_flag = flags_q[FLAG_CMP];
  assign bus.irq      = |(flags_q & bus.irq_en);

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: directed table, multi-cycle corner sequences and
// randomized traffic against a cycle-level behavioural model.
module tb_timer_counter;
  import timer_pkg::*;

  localparam int W    = 8;
  localparam int NF   = NUM_FLAGS;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  timer_counter_if #(.WIDTH(W)) bus ();

  timer_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clock_valid = 1'b0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.one_shot    = 1'b0;
    bus.period      = '0;
    bus.compare     = '0;
    bus.load        = 1'b0;
    bus.load_value  = '0;
    bus.flag_clr    = '0;
    bus.irq_en      = '0;
`ifdef TIMER_CAPTURE_EN
    bus.capture_in  = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  typedef struct {
    bit        st, sp, cv, ld;
    bit [7:0]  lv, per, cmpv;
    bit [1:0]  clr, en;
    bit [7:0]  e_cnt;
    bit        e_run, e_ovf, e_cmp, e_irq;
  } vec_t;

  function automatic vec_t mk(bit st, bit sp, bit cv, bit ld, bit [7:0] lv, bit [7:0] per,
                              bit [7:0] cmpv, bit [1:0] clr, bit [1:0] en, bit [7:0] e_cnt,
                              bit e_run, bit e_ovf, bit e_cmp, bit e_irq);
    vec_t r;
    r.st = st; r.sp = sp; r.cv = cv; r.ld = ld; r.lv = lv; r.per = per; r.cmpv = cmpv;
    r.clr = clr; r.en = en; r.e_cnt = e_cnt; r.e_run = e_run; r.e_ovf = e_ovf;
    r.e_cmp = e_cmp; r.e_irq = e_irq;
    return r;
  endfunction

  vec_t tbl[$];

  // behavioural model state
  int m_st;   // 0 idle, 1 running, 2 done
  int m_cnt;
  bit m_ovf, m_cmp;

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // reset state
    step();
    chk("rst.count",   bus.count,    0);
    chk("rst.running", bus.running,  0);
    chk("rst.ovf",     bus.ovf_flag, 0);
    chk("rst.cmp",     bus.cmp_flag, 0);
    chk("rst.irq",     bus.irq,      0);
    rst_n = 1'b1;
    step();

    // directed table: one row per clock, outputs checked after the edge
    //          st sp cv ld  lv per cmp clr en   cnt run ovf cmp irq
    tbl.push_back(mk(1,0,1,0,  0,  3,200, 0,1,   0, 1,0,0,0));
    tbl.push_back(mk(0,0,1,0,  0,  3,200, 0,1,   1, 1,0,0,0));
    tbl.push_back(mk(0,0,1,0,  0,  3,200, 0,1,   2, 1,0,0,0));
    tbl.push_back(mk(0,0,1,0,  0,  3,200, 0,1,   3, 1,0,0,0));
    tbl.push_back(mk(0,0,1,0,  0,  3,200, 0,1,   0, 1,1,0,1));
    tbl.push_back(mk(0,0,1,0,  0,  3,200, 1,1,   1, 1,0,0,0));
    tbl.push_back(mk(0,0,1,0,  0,  3,200, 0,1,   2, 1,0,0,0));
    tbl.push_back(mk(0,0,1,0,  0,  3,200, 0,1,   3, 1,0,0,0));
    tbl.push_back(mk(0,0,1,0,  0,  3,200, 1,1,   0, 1,1,0,1));
    tbl.push_back(mk(0,0,0,0,  0,  3,200, 1,1,   0, 1,0,0,0));
    tbl.push_back(mk(0,0,1,1,  7,  3,200, 0,1,   7, 1,0,0,0));
    tbl.push_back(mk(0,0,1,0,  0,  3,200, 0,1,   8, 1,0,0,0));
    tbl.push_back(mk(0,1,0,0,  0,  3,200, 0,1,   8, 0,0,0,0));
    tbl.push_back(mk(0,0,1,0,  0,  3,200, 0,1,   8, 0,0,0,0));
    tbl.push_back(mk(0,0,0,1,  0,  9,  2, 0,3,   0, 0,0,0,0));
    tbl.push_back(mk(1,0,0,0,  0,  9,  2, 0,3,   0, 1,0,0,0));
    tbl.push_back(mk(0,0,1,0,  0,  9,  2, 0,3,   1, 1,0,0,0));
    tbl.push_back(mk(0,0,1,0,  0,  9,  2, 0,3,   2, 1,0,1,1));
    tbl.push_back(mk(0,0,0,0,  0,  9,  2, 2,3,   2, 1,0,0,0));
    tbl.push_back(mk(1,1,0,0,  0,  9,  2, 0,3,   2, 0,0,0,0));
    tbl.push_back(mk(1,0,0,0,  0,  9,  2, 0,3,   2, 1,0,0,0));
    tbl.push_back(mk(1,0,1,0,  0,  9,  2, 0,3,   3, 1,0,0,0));
    tbl.push_back(mk(0,0,0,1,  0,  0,  2, 0,3,   0, 1,0,0,0));
    tbl.push_back(mk(0,0,1,0,  0,  0,  2, 0,3,   0, 1,1,0,1));
    tbl.push_back(mk(0,0,1,0,  0,  0,  2, 1,3,   0, 1,1,0,1));
    tbl.push_back(mk(0,0,0,1,254,  3,  0, 1,3, 254, 1,0,0,0));
    tbl.push_back(mk(0,0,1,0,  0,  3,  0, 0,3, 255, 1,0,0,0));
    tbl.push_back(mk(0,0,1,0,  0,  3,  0, 0,3,   0, 1,0,1,1));

    foreach (tbl[i]) begin
      bus.start       = tbl[i].st;
      bus.stop        = tbl[i].sp;
      bus.clock_valid = tbl[i].cv;
      bus.load        = tbl[i].ld;
      bus.load_value  = tbl[i].lv;
      bus.period      = tbl[i].per;
      bus.compare     = tbl[i].cmpv;
      bus.flag_clr    = '0;
      bus.flag_clr[1:0] = tbl[i].clr;
      bus.irq_en      = '0;
      bus.irq_en[1:0] = tbl[i].en;
      step();
      chk($sformatf("tbl%0d.count", i), bus.count,    tbl[i].e_cnt);
      chk($sformatf("tbl%0d.run", i),   bus.running,  tbl[i].e_run);
      chk($sformatf("tbl%0d.ovf", i),   bus.ovf_flag, tbl[i].e_ovf);
      chk($sformatf("tbl%0d.cmp", i),   bus.cmp_flag, tbl[i].e_cmp);
      chk($sformatf("tbl%0d.irq", i),   bus.irq,      tbl[i].e_irq);
    end

    // one-shot: 0,1,2,0 then DONE and frozen
    do_reset();
    bus.one_shot = 1'b1; bus.period = 2; bus.clock_valid = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("os.start.count", bus.count, 0);
    step(); chk("os.c1", bus.count, 1);
    step(); chk("os.c2", bus.count, 2);
    step(); chk("os.wrap", bus.count, 0);
    chk("os.ovf", bus.ovf_flag, 1);
    chk("os.done.run", bus.running, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("os.frozen.count", bus.count, 0);
      chk("os.frozen.run", bus.running, 0);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("os.restart.run", bus.running, 1);
    chk("os.restart.count", bus.count, 0);

    // gated ticks: qualifier every 4th cycle, period 5 -> overflow after 24 clk
    do_reset();
    bus.period = 5; bus.compare = 200; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      bus.clock_valid = (c % 4 == 0);
      step();
      chk($sformatf("gate%0d.count", c), bus.count, (c / 4) % 6);
      chk($sformatf("gate%0d.ovf", c), bus.ovf_flag, (c >= 24) ? 1 : 0);
    end

    // reset mid-run is asynchronous
    do_reset();
    bus.period = 9; bus.compare = 200; bus.irq_en = '1; bus.start = 1'b1;
    step();
    bus.start = 1'b0; bus.clock_valid = 1'b1;
    repeat (5) step();
    chk("mid.count5", bus.count, 5);
    rst_n = 1'b0;
    #2;
    chk("mid.async.count", bus.count, 0);
    chk("mid.async.run",   bus.running, 0);
    chk("mid.async.irq",   bus.irq, 0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("mid.needstart.count", bus.count, 0);
    chk("mid.needstart.run",   bus.running, 0);

`ifdef TIMER_CAPTURE_EN
    bus.clock_valid = 1'b0; bus.load = 1'b1; bus.load_value = 4;
    step();
    bus.load = 1'b0;
    bus.capture_in = 1'b1;
    step(); step();
    chk("cap.early", bus.cap_flag, 0);
    step();
    chk("cap.value", bus.capture_value, 4);
    chk("cap.flag", bus.cap_flag, 1);
    bus.capture_in = 1'b0;
    bus.flag_clr = '0; bus.flag_clr[FLAG_CAP] = 1'b1;
    step();
    bus.flag_clr = '0;
    chk("cap.clr", bus.cap_flag, 0);
`endif

    // randomized traffic against the behavioural model
    do_reset();
    m_st = 0; m_cnt = 0; m_ovf = 0; m_cmp = 0;
    for (int n = 0; n < 3000; n++) begin
      bit ovf_ev, cmp_ev, tick;
      int per, cmpv;
      bus.clock_valid = ($urandom_range(0, 1) == 1);
      bus.start       = ($urandom_range(0, 7) == 0);
      bus.stop        = ($urandom_range(0, 24) == 0);
      bus.load        = ($urandom_range(0, 19) == 0);
      bus.load_value  = W'(($urandom_range(0, 3) == 0) ? $urandom_range(0, MASK) : $urandom_range(0, 12));
      if ($urandom_range(0, 15) == 0) bus.one_shot = $urandom_range(0, 1);
      if ($urandom_range(0, 31) == 0)
        bus.period = W'(($urandom_range(0, 3) == 0) ? $urandom_range(0, MASK) : $urandom_range(0, 10));
      if ($urandom_range(0, 31) == 0) bus.compare = W'($urandom_range(0, 10));
      bus.flag_clr    = '0;
      if ($urandom_range(0, 3) == 0) bus.flag_clr[1:0] = 2'($urandom_range(0, 3));
      bus.irq_en      = '0;
      bus.irq_en[1:0] = 2'($urandom_range(0, 3));

      per  = int'(bus.period);
      cmpv = int'(bus.compare);
      ovf_ev = 0; cmp_ev = 0;
      tick = (m_st == 1) && bus.clock_valid && !bus.load;
      if (bus.load) m_cnt = int'(bus.load_value);
      else if (tick) begin
        if (m_cnt == per) begin m_cnt = 0; ovf_ev = 1; end
        else m_cnt = (m_cnt + 1) & MASK;
        cmp_ev = (m_cnt == cmpv);
      end
      if (m_st == 1) begin
        if (bus.stop) m_st = 0;
        else if (ovf_ev && bus.one_shot) m_st = 2;
      end else if (bus.start && !bus.stop) m_st = 1;
      m_ovf = ovf_ev || (m_ovf && !bus.flag_clr[0]);
      m_cmp = cmp_ev || (m_cmp && !bus.flag_clr[1]);

      step();
      chk($sformatf("rand%0d.state", n),
          {bus.count, bus.running, bus.ovf_flag, bus.cmp_flag, bus.irq},
          {W'(m_cnt), (m_st == 1), m_ovf, m_cmp,
           (m_ovf && bus.irq_en[0]) || (m_cmp && bus.irq_en[1])});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 Parameter: WIDTH, 16, counter/period/compare width in bits (legal 2..32).
REQ-002 Port: clk  input  1  system clock; all state rising-edge triggered.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: clock_valid  input  1  count-tick qualifier from the timer input controller (already gated by enable and clock selection).
REQ-005 Port: start  input  1  single-cycle pulse; IDLE/DONE -> RUNNING.
REQ-006 Port: stop  input  1  single-cycle pulse; RUNNING -> IDLE, count held.
REQ-007 Port: one_shot  input  1  1 = stop after first overflow, 0 = periodic.
REQ-008 Port: period  input  WIDTH  terminal count value.
REQ-009 Port: compare  input  WIDTH  compare-match value.
REQ-010 Port: load  input  1  pulse; count <= load_value.
REQ-011 Port: load_value  input  WIDTH  value written by load.
REQ-012 Port: flag_clr  input  2  write-1-clear; bit0 ovf_flag, bit1 cmp_flag.
REQ-013 Port: irq_en  input  2  interrupt enables; bit0 overflow, bit1 compare.
REQ-014 Port: count  output  WIDTH  current counter value.
REQ-015 Port: running  output  1  high while state is RUNNING.
REQ-016 Port: ovf_flag, cmp_flag  output  1 each  sticky event flags.
REQ-017 Port: irq  output  1  (ovf_flag & irq_en[0]) | (cmp_flag & irq_en[1]), combinational from registered flags.

Function
REQ-018 States IDLE, RUNNING, DONE; start moves IDLE/DONE -> RUNNING; stop moves RUNNING -> IDLE; one-shot overflow moves RUNNING -> DONE; start in RUNNING ignored; stop and start same cycle: stop wins.
REQ-019 In RUNNING, a cycle with clock_valid=1 is a tick; count updates at that clock edge (1-cycle latency); no tick outside RUNNING.
REQ-020 Tick with count != period: count <= count+1; tick with count == period: count <= 0 and ovf_flag set (wrap).
REQ-021 period = 0: every tick is an overflow, count stays 0.
REQ-022 count > period (after load or period change): count increments to 2^WIDTH-1, wraps to 0 without setting ovf_flag.
REQ-023 cmp_flag set on the tick where the next count equals compare (including wrap to 0 when compare=0).
REQ-024 load takes priority over a tick in the same cycle; no flag set by load; load allowed in any state.
REQ-025 Flag set and flag_clr in same cycle: set wins.
REQ-026 start from DONE or IDLE does not clear count; software uses load to restart from 0.
REQ-027 period, compare, one_shot sampled every cycle (no shadowing).

Reset
REQ-028 rst_n low asynchronously forces state IDLE, count 0, ovf_flag 0, cmp_flag 0, running 0, irq 0; capture register 0 when present.
REQ-029 Reset mid-count discards the count; first tick after release requires start.

Configuration
REQ-030 Macro TIMER_CAPTURE_EN: when defined, adds input capture_in (1, async), output capture_value (WIDTH) and output cap_flag (1, sticky, cleared by flag_clr bit2, flag_clr widened to 3, irq_en widened to 3).
REQ-031 With TIMER_CAPTURE_EN: capture_in double-flop synchronized; a rising edge latches count into capture_value and sets cap_flag, 3 clk after the edge, in any state.
REQ-032 Without TIMER_CAPTURE_EN: no capture ports, logic, or flag bit; widths as in REQ-012/013.

Structure
REQ-033 Shared package timer_pkg holds the state enum (IDLE, RUNNING, DONE) and flag bit index constants (FLAG_OVF=0, FLAG_CMP=1, FLAG_CAP=2).
REQ-034 One sub-module timer_edge_detect (2-flop synchronizer + rising-edge pulse), instantiated only under TIMER_CAPTURE_EN.

Verification
REQ-035 Periodic: period=3, clock_valid=1 constant, start -> count 0,1,2,3,0,...; ovf_flag set on 3->0 edge; irq high if irq_en[0].
REQ-036 One-shot: one_shot=1, period=2 -> count 0,1,2,0 then state DONE, running=0, count frozen at 0 despite clock_valid.
REQ-037 Gated ticks: clock_valid high every 4th cycle, period=5 -> count changes only on qualified cycles; overflow after 6 ticks (24 clk).
REQ-038 Collision: load=1 with tick, load_value=7 -> count=7, no flags; flag_clr=1 on overflow cycle -> ovf_flag remains 1.
REQ-039 Compare: compare=2, period=9 -> cmp_flag set on 1->2 tick; flag_clr=2'b10 next cycle clears it, irq drops.
REQ-040 Reset mid-run: rst_n low at count=5 -> count 0, IDLE, flags 0 immediately (before next clk edge); with TIMER_CAPTURE_EN, capture_in edge at count=4 -> capture_value=4, cap_flag=1.
